iomem_gpio_bank: RTL and testbench

//  Parametrised GPIO peripheral on the picosoc iomem bus. Provides N_BANKS

---
 rtl/iomem_gpio_bank.sv | 144 ++++++++++++++
 tb/tb_iomem_gpio_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_gpio_bank.sv
// Banked GPIO peripheral on the picosoc iomem bus: per-bank output, direction,
// synchronised input and sticky edge-interrupt registers with a one-cycle ack.
module iomem_gpio_bank #(
  parameter logic [7:0] ADDR_HI = 8'h03,
  parameter int         N_BANKS = 2,
  parameter int         WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  input  logic [N_BANKS*WIDTH-1:0] gpio_i,
  output logic [N_BANKS*WIDTH-1:0] gpio_o,
  output logic [N_BANKS*WIDTH-1:0] gpio_oe,
  output logic                     irq
);
  localparam int NW = N_BANKS * WIDTH;
  localparam logic [2:0] R_OUT  = 3'd0;
  localparam logic [2:0] R_DIR  = 3'd1;
  localparam logic [2:0] R_IN   = 3'd2;
  localparam logic [2:0] R_EN   = 3'd3;
  localparam logic [2:0] R_POL  = 3'd4;
  localparam logic [2:0] R_STAT = 3'd5;

  typedef logic [WIDTH-1:0] word_t;

  word_t         out_q  [N_BANKS];
  word_t         out_d  [N_BANKS];
  word_t         dir_q  [N_BANKS];
  word_t         dir_d  [N_BANKS];
  word_t         en_q   [N_BANKS];
  word_t         en_d   [N_BANKS];
  word_t         pol_q  [N_BANKS];
  word_t         pol_d  [N_BANKS];
  word_t         stat_q [N_BANKS];
  word_t         stat_d [N_BANKS];
  logic [NW-1:0] sync_q, in_q, prev_q;
  logic          ready_q, ready_d;
  logic          irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          hit_s, wr_s, sel_s;
  logic [3:0]    bank_s;
  logic [2:0]    reg_s;
  logic [31:0]   wmask32_s, rv_s, rd_s;
  word_t         wmask_s, wbits_s, edge_s, in_bank_s;

  function automatic word_t merge(input word_t old_v, input word_t bits_v, input word_t mask_v);
    return (old_v & ~mask_v) | bits_v;
  endfunction

  // Bus decode, register next-state, edge detection and read mux
  always_comb begin
    hit_s     = iomem_valid & ~ready_q & (iomem_addr[31:24] == ADDR_HI);
    wr_s      = hit_s & (iomem_wstrb != 4'b0000);
    bank_s    = {1'b0, iomem_addr[7:5]};
    reg_s     = iomem_addr[4:2];
    wmask32_s = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    wmask_s   = wmask32_s[WIDTH-1:0];
    wbits_s   = iomem_wdata[WIDTH-1:0] & wmask_s;
    rd_s      = 32'h0000_0000;
    rv_s      = 32'h0000_0000;
    irq_d     = 1'b0;
    sel_s     = 1'b0;
    edge_s    = {WIDTH{1'b0}};
    in_bank_s = {WIDTH{1'b0}};
    for (int b = 0; b < N_BANKS; b++) begin
      in_bank_s = in_q[b*WIDTH +: WIDTH];
      // An edge is a change of IN whose new level matches the polarity bit
      edge_s    = (in_bank_s ^ prev_q[b*WIDTH +: WIDTH]) & ~(in_bank_s ^ pol_q[b]);
      sel_s     = wr_s & (bank_s == 4'(b));
      out_d[b]  = (sel_s && (reg_s == R_OUT)) ? merge(out_q[b], wbits_s, wmask_s) : out_q[b];
      dir_d[b]  = (sel_s && (reg_s == R_DIR)) ? merge(dir_q[b], wbits_s, wmask_s) : dir_q[b];
      en_d[b]   = (sel_s && (reg_s == R_EN))  ? merge(en_q[b],  wbits_s, wmask_s) : en_q[b];
      pol_d[b]  = (sel_s && (reg_s == R_POL)) ? merge(pol_q[b], wbits_s, wmask_s) : pol_q[b];
      stat_d[b] = ((sel_s && (reg_s == R_STAT)) ? (stat_q[b] & ~wbits_s) : stat_q[b]) | edge_s;
      irq_d     = irq_d | (|(stat_q[b] & en_q[b]));
      case (reg_s)
        R_OUT:   rv_s = 32'(out_q[b]);
        R_DIR:   rv_s = 32'(dir_q[b]);
        R_IN:    rv_s = 32'(in_bank_s);
        R_EN:    rv_s = 32'(en_q[b]);
        R_POL:   rv_s = 32'(pol_q[b]);
        R_STAT:  rv_s = 32'(stat_q[b]);
        default: rv_s = 32'h0000_0000;
      endcase
      rd_s = (bank_s == 4'(b)) ? rv_s : rd_s;
    end
    ready_d = hit_s;
    rdata_d = (hit_s && !wr_s) ? rd_s : 32'h0000_0000;
  end

  // State registers, input synchroniser chain and registered bus/irq outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < N_BANKS; b++) begin
        out_q[b]  <= {WIDTH{1'b0}};
        dir_q[b]  <= {WIDTH{1'b0}};
        en_q[b]   <= {WIDTH{1'b0}};
        pol_q[b]  <= {WIDTH{1'b0}};
        stat_q[b] <= {WIDTH{1'b0}};
      end
      sync_q  <= {NW{1'b0}};
      in_q    <= {NW{1'b0}};
      prev_q  <= {NW{1'b0}};
      ready_q <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        out_q[b]  <= out_d[b];
        dir_q[b]  <= dir_d[b];
        en_q[b]   <= en_d[b];
        pol_q[b]  <= pol_d[b];
        stat_q[b] <= stat_d[b];
      end
      sync_q  <= gpio_i;
      in_q    <= sync_q;
      prev_q  <= in_q;
      ready_q <= ready_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  // Pack per-bank output and direction registers onto the pin buses
  always_comb begin
    gpio_o  = {NW{1'b0}};
    gpio_oe = {NW{1'b0}};
    for (int b = 0; b < N_BANKS; b++) begin
      gpio_o[b*WIDTH +: WIDTH]  = out_q[b];
      gpio_oe[b*WIDTH +: WIDTH] = dir_q[b];
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Bench for iomem_gpio_bank (2 banks x 8 pins): directed scenarios followed by
// random bus traffic and pin toggling, checked against a pin-history model.
module tb_iomem_gpio_bank;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic [15:0] gpio_i = 16'h0;
  logic [15:0] gpio_o, gpio_oe;
  logic        irq;

  int n_pass = 0;
  int n_total = 0;

  // Model: register contents per bank plus the history of pin values seen at each edge
  logic [7:0]  m_out [2], m_dir [2], m_en [2], m_pol [2], m_stat [2];
  logic [15:0] ph [$];
  logic        m_ready;

  iomem_gpio_bank #(.ADDR_HI(8'h03), .N_BANKS(2), .WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      m_out[b] = 8'h00; m_dir[b] = 8'h00; m_en[b] = 8'h00; m_pol[b] = 8'h00; m_stat[b] = 8'h00;
    end
    ph.delete();
    m_ready = 1'b0;
  endtask

  function automatic logic [15:0] hget(input int i);
    if (i < 0 || i >= ph.size()) return 16'h0000;
    return ph[i];
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] bank, input logic [2:0] rg, input logic [15:0] pins);
    if (bank >= 3'd2) return 32'h0;
    case (rg)
      3'd0:    return {24'h0, m_out[bank]};
      3'd1:    return {24'h0, m_dir[bank]};
      3'd2:    return {24'h0, pins[bank*8 +: 8]};
      3'd3:    return {24'h0, m_en[bank]};
      3'd4:    return {24'h0, m_pol[bank]};
      3'd5:    return {24'h0, m_stat[bank]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic mwrite(input logic [2:0] bank, input logic [2:0] rg, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] m32;
    logic [7:0]  m;
    m32 = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    m   = m32[7:0];
    case (rg)
      3'd0:    m_out[bank] = (m_out[bank] & ~m) | (d[7:0] & m);
      3'd1:    m_dir[bank] = (m_dir[bank] & ~m) | (d[7:0] & m);
      3'd3:    m_en[bank]  = (m_en[bank] & ~m) | (d[7:0] & m);
      3'd4:    m_pol[bank] = (m_pol[bank] & ~m) | (d[7:0] & m);
      3'd5:    m_stat[bank] = m_stat[bank] & ~(d[7:0] & m);
      default: ;
    endcase
  endtask

  // One clock: predict the edge's effect from the pin history, then compare outputs
  task automatic tick();
    int          k;
    logic        hitm, rdm, irqn;
    logic [31:0] rd;
    logic [15:0] nin, old;
    logic [7:0]  ed [2];
    logic [2:0]  bank, rg;
    k    = ph.size();
    nin  = hget(k - 2);
    old  = hget(k - 3);
    irqn = 1'b0;
    for (int b = 0; b < 2; b++) begin
      ed[b] = (nin[b*8 +: 8] ^ old[b*8 +: 8]) & ~(nin[b*8 +: 8] ^ m_pol[b]);
      irqn  = irqn | (|(m_stat[b] & m_en[b]));
    end
    bank = iomem_addr[7:5];
    rg   = iomem_addr[4:2];
    hitm = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h03);
    rdm  = hitm && (iomem_wstrb == 4'h0);
    rd   = rdm ? mread(bank, rg, nin) : 32'h0;
    if (hitm && iomem_wstrb != 4'h0 && bank < 3'd2) mwrite(bank, rg, iomem_wstrb, iomem_wdata);
    for (int b = 0; b < 2; b++) m_stat[b] = m_stat[b] | ed[b];
    ph.push_back(gpio_i);
    @(posedge clk); #1;
    m_ready = hitm;
    chk("ready", {31'h0, iomem_ready}, {31'h0, m_ready});
    chk("irq", {31'h0, irq}, {31'h0, irqn});
    chk("gpio_o", {16'h0, gpio_o}, {16'h0, m_out[1], m_out[0]});
    chk("gpio_oe", {16'h0, gpio_oe}, {16'h0, m_dir[1], m_dir[0]});
    if (rdm) chk("rdata", iomem_rdata, rd);
  endtask

  // Request held for two cycles: ack in the first, never in the second
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] r);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    tick();
    r = iomem_rdata;
    chk("ack", {31'h0, iomem_ready}, {31'h0, (a[31:24] == 8'h03)});
    tick();
    chk("ack_width", {31'h0, iomem_ready}, 32'h0);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  initial begin
    logic [31:0] r, a;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
    chk("rst_rdata", iomem_rdata, 32'h0);
    chk("rst_gpio_o", {16'h0, gpio_o}, 32'h0);
    chk("rst_gpio_oe", {16'h0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    model_clear();

    for (int i = 0; i < 6; i++) begin
      bus(32'h0300_0000 + 32'(4 * i), 4'h0, 32'h0, r);
      chk("t1_read0", r, 32'h0);
    end

    bus(32'h0300_0000, 4'b0001, 32'h0000_00A5, r);
    chk("t2_out", {24'h0, gpio_o[7:0]}, 32'hA5);
    bus(32'h0300_0004, 4'b0001, 32'h0000_000F, r);
    chk("t2_dir", {24'h0, gpio_oe[7:0]}, 32'h0F);
    bus(32'h0300_0000, 4'b1111, 32'hFFFF_FF3C, r);
    bus(32'h0300_0000, 4'h0, 32'h0, r);
    chk("t2_clip", r, 32'h3C);
    bus(32'h0300_0020, 4'b0010, 32'h0000_5A00, r);
    bus(32'h0300_0020, 4'h0, 32'h0, r);
    chk("t2_hi_strobe", r, 32'h0);

    bus(32'h0300_0010, 4'b0001, 32'h01, r);
    bus(32'h0300_000C, 4'b0001, 32'h01, r);
    gpio_i[0] = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("t3_irq_timing", {31'h0, irq}, {31'h0, (t == 4)});
    end
    bus(32'h0300_0014, 4'h0, 32'h0, r);
    chk("t3_stat", r, 32'h01);
    bus(32'h0300_0008, 4'h0, 32'h0, r);
    chk("t3_in", r, 32'h01);
    bus(32'h0300_0014, 4'b0001, 32'h01, r);
    chk("t3_irq_clr", {31'h0, irq}, 32'h0);

    gpio_i[8] = 1'b1;
    repeat (4) tick();
    gpio_i[8] = 1'b0;
    repeat (4) tick();
    bus(32'h0300_0034, 4'h0, 32'h0, r);
    chk("t4_stat1", r, 32'h01);
    chk("t4_irq_off", {31'h0, irq}, 32'h0);
    bus(32'h0300_002C, 4'b0001, 32'h01, r);
    chk("t4_irq_on", {31'h0, irq}, 32'h1);
    bus(32'h0300_0034, 4'b0001, 32'h01, r);

    gpio_i[0] = 1'b0;
    repeat (4) tick();
    gpio_i[0] = 1'b1;
    tick();
    tick();
    bus(32'h0300_0014, 4'b0001, 32'h01, r);
    bus(32'h0300_0014, 4'h0, 32'h0, r);
    chk("t5_set_wins", r, 32'h01);

    bus(32'h0300_00E0, 4'h0, 32'h0, r);
    chk("t6_bank7_rd", r, 32'h0);
    bus(32'h0300_00E0, 4'b1111, 32'hFFFF_FFFF, r);
    bus(32'h0300_0000, 4'h0, 32'h0, r);
    chk("t6_no_change", r, 32'h3C);
    bus(32'h0400_0000, 4'h0, 32'h0, r);
    chk("t6_miss_noack", {31'h0, iomem_ready}, 32'h0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) gpio_i = gpio_i ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        tick();
      end else begin
        a = {($urandom_range(0, 7) == 0) ? 8'h04 : 8'h03, 16'($urandom), 3'($urandom_range(0, 7) % 3),
             3'($urandom_range(0, 7)), 2'($urandom)};
        if ($urandom_range(0, 5) == 0) a[7:5] = 3'($urandom_range(2, 7));
        bus(a, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), $urandom, r);
      end
    end

    iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'h0;
    #2 reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      chk("rst_mid_ready", {31'h0, iomem_ready}, 32'h0);
      chk("rst_mid_gpio_o", {16'h0, gpio_o}, 32'h0);
    end
    iomem_valid = 1'b0;
    reset = 1'b0;
    model_clear();
    tick();
    chk("post_rst_ready", {31'h0, iomem_ready}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
